ex_mem_pipeline_register: RTL and testbench
===========================================

Name: ex_mem_pipeline_register

Overview:
- Pipeline register between the execute stage and the memory stage.
- Captures the execute-stage instruction and ALU result, then builds the memory write-data word.
- Write data is assembled as top and bottom halves, each chosen by the one-hot selects from memory_forwarding_logic.
- Returns the registered opcode (ex_mem_instruction) to the forwarding logic.
- Uses a valid/ready handshake with stall and flush.

Parameters:
- DATA_WIDTH, 16: datapath width. Must be even; split into top and bottom halves.
- INSTR_WIDTH, 32: instruction word width.
- NOP_OPCODE, 8'h00: opcode driven when the register is empty or flushed.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  execute stage presents a valid instruction.
- ex_ready  out  1  this block can accept an instruction this cycle.
- ex_instruction  in  INSTR_WIDTH  execute-stage instruction; opcode is [7:0].
- ex_alu_result  in  DATA_WIDTH  execute ALU result / memory address.
- rf_read_data  in  DATA_WIDTH  register-file store operand.
- sfr_read_data  in  DATA_WIDTH  SFR read operand.
- mem_wb_data  in  DATA_WIDTH  MEM/WB writeback value (forward source).
- sfr_input_sel  in  1  1 = source 0 is sfr_read_data; 0 = source 0 is rf_read_data.
- mem_write_data_sel_top  in  4  one-hot select for the top half.
- mem_write_data_sel_bot  in  4  one-hot select for the bottom half.
- flush  in  1  discard contents and empty the stage.
- mem_ready  in  1  memory stage accepts the current contents.
- mem_valid  out  1  registered contents are valid.
- mem_instruction  out  INSTR_WIDTH  registered instruction.
- ex_mem_instruction  out  8  registered opcode while mem_valid, else NOP_OPCODE.
- mem_alu_result  out  DATA_WIDTH  registered ALU result.
- mem_write_data  out  DATA_WIDTH  registered assembled write data.
- sel_error  out  1  sticky flag: a non-one-hot select was captured.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - mem_valid=0, sel_error=0.
  - mem_instruction = {INSTR_WIDTH-8 zeros, NOP_OPCODE}.
  - mem_alu_result=0, mem_write_data=0.
  - FSM goes to EMPTY.
- FSM has two states, EMPTY and FULL. mem_valid = (state==FULL).
- ex_ready = !mem_valid | mem_ready. This is combinational and has no dependence on ex_valid.
- Capture happens when ex_valid & ex_ready & !flush. It takes effect on the next edge: state becomes FULL and all mem_* outputs are loaded. Latency is one cycle.
- Drain: in FULL with mem_ready=1 and no capture, next state is EMPTY and the instruction is replaced by NOP.
- Simultaneous drain and capture: state stays FULL and the new contents are loaded (back-to-back throughput of one per cycle).
- Stall: in FULL with mem_ready=0, all outputs hold bit-exact.
- Flush has highest priority among the synchronous events:
  - Next state is EMPTY and the instruction becomes NOP.
  - Data registers hold their values; they are don't-care while empty.
  - Any capture in the same cycle is dropped.
  - Applies in either state, including mid-stall.
- Write-data half mux (H = DATA_WIDTH/2). The top half uses source bits [DATA_WIDTH-1:H]; the bottom half uses [H-1:0].
  - Select bit 0: sfr_input_sel ? sfr_read_data : rf_read_data.
  - Select bit 1: the block's current mem_alu_result (EX/MEM forward). If the block is empty, the stale register value is used.
  - Select bit 2: mem_wb_data.
  - Select bit 3: ex_instruction[INSTR_WIDTH-1:INSTR_WIDTH-DATA_WIDTH] (immediate).
- Select errors:
  - A zero or multi-hot select yields a zero half.
  - If that select is captured, sel_error sets. It clears only on reset.
- Selects are sampled only on capture.
- ex_mem_instruction is combinational from mem_valid and the registered opcode.

Optional Feature:
- Macro: EX_MEM_STALL_CNT_EN.
- When defined:
  - Adds output stall_count, 16 bits.
  - Increments on each cycle with mem_valid & !mem_ready.
  - Saturates at 16'hFFFF.
  - Reset to 0 asynchronously.
  - flush does not clear it.
- When undefined: the port and logic are absent. All other behaviour is identical.

Decomposition:
- Shared package soc_pipeline_pkg holds:
  - the NOP_OPCODE constant;
  - select bit-index constants SEL_RF_SFR=0, SEL_EXMEM=1, SEL_MEMWB=2, SEL_IMM=3;
  - the EMPTY/FULL state typedef.
- One sub-module, write_data_half_mux (4-source one-hot mux with error output), instantiated twice (top, bottom).

Test Plan:
- Reset with reset_n=0 mid-stall while FULL → outputs go to reset values immediately (asynchronous); ex_mem_instruction=8'h00, ex_ready=1.
- ex_valid=1, opcode 8'hC4, rf_read_data=16'hA55A, both sels=4'b0001, mem_ready=1 → next cycle mem_valid=1, mem_write_data=16'hA55A, ex_mem_instruction=8'hC4.
- Split select: sel_top=4'b0100 with mem_wb_data=16'h12xx, sel_bot=4'b0010 with held mem_alu_result=16'hxx34 → mem_write_data=16'h1234.
- mem_ready=0 for 3 cycles while FULL → ex_ready=0, outputs stable; stall_count=3 with EX_MEM_STALL_CNT_EN.
- flush together with ex_valid while FULL and stalled → next cycle mem_valid=0, ex_mem_instruction=8'h00, new instruction not captured.
- Capture with sel_top=4'b0011 → top half 8'h00, sel_error=1 and remains 1 through later valid traffic.

Source files
------------

// File: rtl/soc_pipeline_pkg.sv
// rtl/soc_pipeline_pkg.sv - shared constants and state type for the EX/MEM pipeline slice
package soc_pipeline_pkg;

  localparam logic [7:0] NOP_OPCODE = 8'h00;

  // Bit positions within the one-hot write-data selects
  localparam int SEL_RF_SFR = 0;
  localparam int SEL_EXMEM  = 1;
  localparam int SEL_MEMWB  = 2;
  localparam int SEL_IMM    = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ex_mem_state_t;

endpackage

// File: rtl/write_data_half_mux.sv
// rtl/write_data_half_mux.sv - one-hot 4-source mux for one half of the memory write data
module write_data_half_mux #(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       sel,
  input  logic [WIDTH-1:0] src_rf_sfr,
  input  logic [WIDTH-1:0] src_exmem,
  input  logic [WIDTH-1:0] src_memwb,
  input  logic [WIDTH-1:0] src_imm,
  output logic [WIDTH-1:0] data,
  output logic             sel_error
);
  import soc_pipeline_pkg::*;

  // Anything other than exactly one select bit produces a zero half
  always_comb begin
    data      = '0;
    sel_error = ($countones(sel) != 1);
    if (!sel_error) begin
      if (sel[SEL_RF_SFR]) data = src_rf_sfr;
      if (sel[SEL_EXMEM])  data = src_exmem;
      if (sel[SEL_MEMWB])  data = src_memwb;
      if (sel[SEL_IMM])    data = src_imm;
    end
  end

endmodule

// File: rtl/ex_mem_pipeline_register.sv
// rtl/ex_mem_pipeline_register.sv - EX/MEM pipeline register with valid/ready, flush and write-data assembly
// Optional stall counter output enabled by EX_MEM_STALL_CNT_EN.
module ex_mem_pipeline_register #(
  parameter int         DATA_WIDTH  = 16,
  parameter int         INSTR_WIDTH = 32,
  parameter logic [7:0] NOP_OPCODE  = soc_pipeline_pkg::NOP_OPCODE
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   ex_valid,
  output logic                   ex_ready,
  input  logic [INSTR_WIDTH-1:0] ex_instruction,
  input  logic [DATA_WIDTH-1:0]  ex_alu_result,
  input  logic [DATA_WIDTH-1:0]  rf_read_data,
  input  logic [DATA_WIDTH-1:0]  sfr_read_data,
  input  logic [DATA_WIDTH-1:0]  mem_wb_data,
  input  logic                   sfr_input_sel,
  input  logic [3:0]             mem_write_data_sel_top,
  input  logic [3:0]             mem_write_data_sel_bot,
  input  logic                   flush,
  input  logic                   mem_ready,
  output logic                   mem_valid,
  output logic [INSTR_WIDTH-1:0] mem_instruction,
  output logic [7:0]             ex_mem_instruction,
  output logic [DATA_WIDTH-1:0]  mem_alu_result,
  output logic [DATA_WIDTH-1:0]  mem_write_data,
  output logic                   sel_error
`ifdef EX_MEM_STALL_CNT_EN
  ,
  output logic [15:0]            stall_count
`endif
);
  import soc_pipeline_pkg::*;

  localparam int H = DATA_WIDTH / 2;
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = {{(INSTR_WIDTH-8){1'b0}}, NOP_OPCODE};

  ex_mem_state_t state_q, state_d;
  logic capture;
  logic drain;

  logic [DATA_WIDTH-1:0] src_rf_sfr;
  logic [DATA_WIDTH-1:0] src_imm;
  logic [H-1:0]          wdata_top;
  logic [H-1:0]          wdata_bot;
  logic                  err_top;
  logic                  err_bot;

  assign mem_valid          = (state_q == FULL);
  assign ex_ready           = !mem_valid || mem_ready;
  assign capture            = ex_valid && ex_ready && !flush;
  assign drain              = mem_valid && mem_ready;
  assign ex_mem_instruction = mem_valid ? mem_instruction[7:0] : NOP_OPCODE;

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else if (capture) begin
      state_d = FULL;
    end else if (drain) begin
      state_d = EMPTY;
    end
  end

  assign src_rf_sfr = sfr_input_sel ? sfr_read_data : rf_read_data;
  assign src_imm    = ex_instruction[INSTR_WIDTH-1 -: DATA_WIDTH];

  // EX/MEM forward uses the registered result even when empty (stale value)
  write_data_half_mux #(.WIDTH(H)) u_mux_top (
    .sel        (mem_write_data_sel_top),
    .src_rf_sfr (src_rf_sfr[DATA_WIDTH-1:H]),
    .src_exmem  (mem_alu_result[DATA_WIDTH-1:H]),
    .src_memwb  (mem_wb_data[DATA_WIDTH-1:H]),
    .src_imm    (src_imm[DATA_WIDTH-1:H]),
    .data       (wdata_top),
    .sel_error  (err_top)
  );

  write_data_half_mux #(.WIDTH(H)) u_mux_bot (
    .sel        (mem_write_data_sel_bot),
    .src_rf_sfr (src_rf_sfr[H-1:0]),
    .src_exmem  (mem_alu_result[H-1:0]),
    .src_memwb  (mem_wb_data[H-1:0]),
    .src_imm    (src_imm[H-1:0]),
    .data       (wdata_bot),
    .sel_error  (err_bot)
  );

  // Data registers only move on capture; flush and drain just retire the instruction to NOP
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= EMPTY;
      mem_instruction <= NOP_INSTR;
      mem_alu_result  <= '0;
      mem_write_data  <= '0;
      sel_error       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        mem_instruction <= NOP_INSTR;
      end else if (capture) begin
        mem_instruction <= ex_instruction;
        mem_alu_result  <= ex_alu_result;
        mem_write_data  <= {wdata_top, wdata_bot};
        sel_error       <= sel_error || err_top || err_bot;
      end else if (drain) begin
        mem_instruction <= NOP_INSTR;
      end
    end
  end

`ifdef EX_MEM_STALL_CNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= 16'h0000;
    end else if (mem_valid && !mem_ready && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_pipeline_register.sv
// tb/tb_ex_mem_pipeline_register.sv - self-checking bench for ex_mem_pipeline_register
module tb_ex_mem_pipeline_register;
  localparam int DW = 16;
  localparam int IW = 32;
  localparam int H  = DW / 2;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          ex_valid;
  logic          ex_ready;
  logic [IW-1:0] ex_instruction;
  logic [DW-1:0] ex_alu_result;
  logic [DW-1:0] rf_read_data;
  logic [DW-1:0] sfr_read_data;
  logic [DW-1:0] mem_wb_data;
  logic          sfr_input_sel;
  logic [3:0]    sel_top;
  logic [3:0]    sel_bot;
  logic          flush;
  logic          mem_ready;
  logic          mem_valid;
  logic [IW-1:0] mem_instruction;
  logic [7:0]    ex_mem_instruction;
  logic [DW-1:0] mem_alu_result;
  logic [DW-1:0] mem_write_data;
  logic          sel_error;
`ifdef EX_MEM_STALL_CNT_EN
  logic [15:0]   stall_count;
`endif

  ex_mem_pipeline_register #(.DATA_WIDTH(DW), .INSTR_WIDTH(IW), .NOP_OPCODE(8'h00)) dut (
    .clock                  (clock),
    .reset_n                (reset_n),
    .ex_valid               (ex_valid),
    .ex_ready               (ex_ready),
    .ex_instruction         (ex_instruction),
    .ex_alu_result          (ex_alu_result),
    .rf_read_data           (rf_read_data),
    .sfr_read_data          (sfr_read_data),
    .mem_wb_data            (mem_wb_data),
    .sfr_input_sel          (sfr_input_sel),
    .mem_write_data_sel_top (sel_top),
    .mem_write_data_sel_bot (sel_bot),
    .flush                  (flush),
    .mem_ready              (mem_ready),
    .mem_valid              (mem_valid),
    .mem_instruction        (mem_instruction),
    .ex_mem_instruction     (ex_mem_instruction),
    .mem_alu_result         (mem_alu_result),
    .mem_write_data         (mem_write_data),
    .sel_error              (sel_error)
`ifdef EX_MEM_STALL_CNT_EN
    ,
    .stall_count            (stall_count)
`endif
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: what the stage should be holding
  bit            m_valid;
  logic [IW-1:0] m_instr;
  logic [DW-1:0] m_alu;
  logic [DW-1:0] m_wdata;
  bit            m_err;
  int            m_stall;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_instr = '0;
    m_alu   = '0;
    m_wdata = '0;
    m_err   = 0;
    m_stall = 0;
  endtask

  function automatic logic [H-1:0] half_model(input logic [3:0] sel, input bit top);
    logic [DW-1:0] src [4];
    src[0] = sfr_input_sel ? sfr_read_data : rf_read_data;
    src[1] = m_alu;
    src[2] = mem_wb_data;
    src[3] = ex_instruction[IW-1:IW-DW];
    if ($countones(sel) != 1) return '0;
    for (int i = 0; i < 4; i++)
      if (sel[i]) return top ? src[i][DW-1:H] : src[i][H-1:0];
    return '0;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".mem_valid"}, 64'(mem_valid), 64'(m_valid));
    check({tag, ".mem_instruction"}, 64'(mem_instruction), 64'(m_instr));
    check({tag, ".opcode"}, 64'(ex_mem_instruction), 64'(m_valid ? m_instr[7:0] : 8'h00));
    check({tag, ".alu"}, 64'(mem_alu_result), 64'(m_alu));
    check({tag, ".wdata"}, 64'(mem_write_data), 64'(m_wdata));
    check({tag, ".sel_error"}, 64'(sel_error), 64'(m_err));
`ifdef EX_MEM_STALL_CNT_EN
    check({tag, ".stall_count"}, 64'(stall_count), 64'(m_stall));
`endif
  endtask

  // One clock: check ex_ready, predict the edge, then compare all outputs
  task automatic step(input string tag);
    bit            rdy, cap, stalled, fl, mr;
    bit            bad;
    logic [DW-1:0] nw;
    @(negedge clock);
    rdy = !m_valid || mem_ready;
    check({tag, ".ex_ready"}, 64'(ex_ready), 64'(rdy));
    fl      = flush;
    mr      = mem_ready;
    cap     = ex_valid && rdy && !fl;
    stalled = m_valid && !mr;
    nw      = {half_model(sel_top, 1'b1), half_model(sel_bot, 1'b0)};
    bad     = ($countones(sel_top) != 1) || ($countones(sel_bot) != 1);
    @(posedge clock);
    if (stalled && m_stall < 65535) m_stall++;
    if (fl) begin
      m_valid = 0;
      m_instr = '0;
    end else if (cap) begin
      m_valid = 1;
      m_instr = ex_instruction;
      m_alu   = ex_alu_result;
      m_wdata = nw;
      if (bad) m_err = 1;
    end else if (m_valid && mr) begin
      m_valid = 0;
      m_instr = '0;
    end
    #1;
    check_outputs(tag);
  endtask

  function automatic logic [3:0] rand_sel();
    if ($urandom_range(0, 9) == 0) return 4'($urandom_range(0, 15));
    return 4'b0001 << $urandom_range(0, 3);
  endfunction

  initial begin
    reset_n        = 1'b0;
    ex_valid       = 1'b0;
    ex_instruction = '0;
    ex_alu_result  = '0;
    rf_read_data   = '0;
    sfr_read_data  = '0;
    mem_wb_data    = '0;
    sfr_input_sel  = 1'b0;
    sel_top        = 4'b0001;
    sel_bot        = 4'b0001;
    flush          = 1'b0;
    mem_ready      = 1'b1;
    model_reset();
    #12;
    check_outputs("reset");
    check("reset.ex_ready", 64'(ex_ready), 64'd1);
    reset_n = 1'b1;

    // Plain capture through the register-file source
    ex_valid       = 1'b1;
    ex_instruction = 32'hBEEF_00C4;
    ex_alu_result  = 16'h5634;
    rf_read_data   = 16'hA55A;
    step("cap_c4");
    check("cap_c4.wdata_const", 64'(mem_write_data), 64'h0000_A55A);
    check("cap_c4.opcode_const", 64'(ex_mem_instruction), 64'h0000_00C4);

    // Top from MEM/WB, bottom forwarded from the held ALU result
    ex_instruction = 32'h1111_2233;
    ex_alu_result  = 16'h7777;
    mem_wb_data    = 16'h12AB;
    sel_top        = 4'b0100;
    sel_bot        = 4'b0010;
    step("split");
    check("split.wdata_const", 64'(mem_write_data), 64'h0000_1234);

    // Three stalled cycles
    ex_valid  = 1'b0;
    mem_ready = 1'b0;
    sel_top   = 4'b0001;
    sel_bot   = 4'b0001;
    for (int i = 0; i < 3; i++) step("stall");
`ifdef EX_MEM_STALL_CNT_EN
    check("stall.count_const", 64'(stall_count), 64'd3);
`endif

    // Flush while stalled drops the offered instruction
    flush          = 1'b1;
    ex_valid       = 1'b1;
    ex_instruction = 32'hDEAD_BE99;
    step("flush");
    check("flush.valid_const", 64'(mem_valid), 64'd0);
    check("flush.opcode_const", 64'(ex_mem_instruction), 64'd0);
    flush = 1'b0;

    // Multi-hot top select
    mem_ready      = 1'b1;
    ex_instruction = 32'h0000_0011;
    rf_read_data   = 16'hBEEF;
    sel_top        = 4'b0011;
    sel_bot        = 4'b0001;
    step("selerr");
    check("selerr.top_const", 64'(mem_write_data[15:8]), 64'd0);
    check("selerr.flag_const", 64'(sel_error), 64'd1);
    sel_top = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      ex_instruction = $urandom;
      step("selerr_hold");
    end
    check("selerr.sticky_const", 64'(sel_error), 64'd1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      ex_valid       = ($urandom_range(0, 3) != 0);
      ex_instruction = $urandom;
      ex_alu_result  = 16'($urandom);
      rf_read_data   = 16'($urandom);
      sfr_read_data  = 16'($urandom);
      mem_wb_data    = 16'($urandom);
      sfr_input_sel  = 1'($urandom);
      sel_top        = rand_sel();
      sel_bot        = rand_sel();
      flush          = ($urandom_range(0, 15) == 0);
      mem_ready      = ($urandom_range(0, 2) != 0);
      step("rand");
    end
    flush = 1'b0;

    // Asynchronous reset while full and stalled
    ex_valid  = 1'b1;
    mem_ready = 1'b1;
    sel_top   = 4'b1000;
    sel_bot   = 4'b0001;
    step("pre_rst_fill");
    ex_valid  = 1'b0;
    mem_ready = 1'b0;
    step("pre_rst_stall");
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    check("async_rst.ex_ready", 64'(ex_ready), 64'd1);
    check("async_rst.opcode_const", 64'(ex_mem_instruction), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    step("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
